// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus four MMIO registers
// (LED latch, cycle counter, byte TX FIFO push port, TX status).
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h0000_F000,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [15:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0] mem [DEPTH];

  logic [31:0]   q_q, q_d;
  logic [15:0]   leds_q, leds_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [31:0] mmio_off;
  logic        is_ram, is_mmio;
  logic        full, empty;
  logic        push_req, push, pop;
  logic [31:0] status;

  // RAM wins any overlap so one access never reaches two targets.
  assign mmio_off = address_dmem - MMIO_BASE;
  assign is_ram   = address_dmem < 32'(DEPTH);
  assign is_mmio  = !is_ram && (mmio_off < 32'd4);

  assign full     = count_q == CW'(TX_DEPTH);
  assign empty    = count_q == '0;
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign pop      = tx_valid && tx_ready;

  assign push_req = wren && is_mmio && (mmio_off[1:0] == 2'd2);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
  assign push     = push_req && (!full || pop);

  assign status = {25'b0, ovf_q, empty, full, 4'(count_q)};

  always_comb begin
    q_d = 32'b0;
    if (is_ram) begin
      q_d = mem[address_dmem[AW-1:0]];
    end else if (is_mmio) begin
      unique case (mmio_off[1:0])
        2'd0:    q_d = {16'b0, leds_q};
        2'd1:    q_d = cycles_q;
        2'd2:    q_d = 32'b0;
        default: q_d = status;
      endcase
    end
  end

  always_comb begin
    leds_d   = leds_q;
    cycles_d = cycles_q + 32'd1;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wren && is_mmio) begin
      unique case (mmio_off[1:0])
        2'd0:    leds_d   = data[15:0];
        2'd1:    cycles_d = 32'b0;
        2'd2:    if (full && !pop) ovf_d = 1'b1;
        default: ovf_d    = 1'b0;
      endcase
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // RAM and FIFO storage are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wren && is_ram) mem[address_dmem[AW-1:0]] <= data;
    if (push) fifo_q[wr_ptr_q] <= data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q      <= 32'b0;
      leds_q   <= 16'b0;
      cycles_q <= 32'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      leds_q   <= leds_d;
      cycles_q <= cycles_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign q_dmem = q_q;
  assign leds   = leds_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for RAM/MMIO reads and
// writes, hand-written sequences for FIFO fill/drain and async reset.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h0000_F000;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [15:0] leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int tests;
  int fails;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .leds         (leds),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk_q;
    logic [31:0] exp_q;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    address_dmem = a;
    data         = d;
    wren         = we;
  endtask

  task automatic push_byte(input logic [7:0] b);
    drive(MB + 32'd2, {24'b0, b}, 1'b1);
    tick();
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    drive(MB + 32'd3, 32'b0, 1'b0);
    tick();
    check(name, q_dmem, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    tx_ready = 1'b0;
    drive(32'b0, 32'b0, 1'b0);

    // {addr, wdata, we, chk_q, exp_q, exp_leds}; exp_q is q_dmem after the edge
    vecs[0]  = '{32'd5,      32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         16'h0};
    vecs[1]  = '{32'd5,      32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 16'h0};
    vecs[2]  = '{32'd5,      32'h1,         1'b1, 1'b1, 32'hDEAD_BEEF, 16'h0};
    vecs[3]  = '{32'd5,      32'h0,         1'b0, 1'b1, 32'h1,         16'h0};
    vecs[4]  = '{MB,         32'h1234_ABCD, 1'b1, 1'b1, 32'h0,         16'hABCD};
    vecs[5]  = '{32'd40000,  32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
    vecs[6]  = '{MB,         32'h0,         1'b0, 1'b1, 32'h0000_ABCD, 16'hABCD};
    vecs[7]  = '{MB + 32'd1, 32'h5555_5555, 1'b1, 1'b0, 32'h0,         16'hABCD};
    vecs[8]  = '{MB + 32'd1, 32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
    vecs[9]  = '{MB + 32'd1, 32'h0,         1'b0, 1'b1, 32'h1,         16'hABCD};
    vecs[10] = '{32'h40,     32'h0000_AAAA, 1'b1, 1'b0, 32'h0,         16'hABCD};
    vecs[11] = '{32'h1040,   32'h0000_BBBB, 1'b1, 1'b1, 32'h0,         16'hABCD};
    vecs[12] = '{32'h40,     32'h0,         1'b0, 1'b1, 32'h0000_AAAA, 16'hABCD};
    vecs[13] = '{MB + 32'd2, 32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
    vecs[14] = '{MB + 32'd3, 32'h0,         1'b0, 1'b1, 32'h20,        16'hABCD};

    // Reset held while clocking
    repeat (3) tick();
    check("rst_q", q_dmem, 32'h0);
    check("rst_leds", {16'b0, leds}, 32'h0);
    check("rst_valid", {31'b0, tx_valid}, 32'h0);
    reset = 1'b1;
    read_status("rst_status", 32'h20);

    // Basic RAM / MMIO table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      tick();
      if (vecs[i].chk_q) check($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
      check($sformatf("vec%0d_leds", i), {16'b0, leds}, {16'b0, vecs[i].exp_leds});
    end

    // FIFO fill with overflow, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i));
    read_status("fill_status", 32'h54);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), {31'b0, tx_valid}, 32'h1);
      check($sformatf("drain%0d_data", i), {24'b0, tx_data}, {24'b0, 8'h41 + 8'(i)});
      tick();
    end
    check("drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    read_status("drain_status", 32'h60);

    // Clear overflow, fill, then push+pop on the same edge while full
    drive(MB + 32'd3, 32'hFFFF_FFFF, 1'b1);
    tick();
    read_status("ovf_clear", 32'h20);
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
    check("full_head", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    push_byte(8'h55);
    tx_ready = 1'b0;
    read_status("pushpop_status", 32'h14);
    tx_ready = 1'b1;
    begin
      logic [7:0] exp_order [4];
      exp_order[0] = 8'h42; exp_order[1] = 8'h43; exp_order[2] = 8'h44; exp_order[3] = 8'h55;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("pp_drain%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, exp_order[i]});
        tick();
      end
    end
    check("pp_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Async reset with 3 bytes queued mid-drain
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
    drive(MB + 32'd1, 32'h0, 1'b0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("mid_head", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h62});
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {31'b0, tx_valid}, 32'h0);
    check("async_leds", {16'b0, leds}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("cyc_restart0", q_dmem, 32'h0);
    tick();
    check("cyc_restart1", q_dmem, 32'h1);
    read_status("post_rst_status", 32'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
